byte_data_memory: RTL and testbench

- Parametrised successor of the single-cycle data memory: word-organised RAM with byte addressing, byte/half/word stores placed in the correct byte lanes, and sign- or zero-extended sub-word loads.
- Adds a valid/ready request port, a configurable read-latency pipeline, alignment and range error reporting, and a hardware clear sequencer run after reset.
- Sits between the datapath's load/store stage and the register-file writeback.

---
 rtl/byte_data_memory_pkg.sv | 36 +++
 rtl/dmem_load_align.sv | 29 ++
 rtl/byte_data_memory.sv | 147 ++++++++++++++
 tb/tb_byte_data_memory.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/byte_data_memory_pkg.sv
// Shared encodings for the byte-addressed data memory: access sizes,
// sequencer states and the store byte-lane helpers.
package byte_data_memory_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_RSVD = 2'b11
   } size_e;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_e;

   // Byte lanes touched by a store of the given size at the given byte offset.
   function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] offset);
      case (size)
         SZ_BYTE: lane_mask = 4'b0001 << offset;
         SZ_HALF: lane_mask = offset[1] ? 4'b1100 : 4'b0011;
         SZ_WORD: lane_mask = 4'b1111;
         default: lane_mask = 4'b0000;
      endcase
   endfunction

   // Right-aligned store data replicated so every candidate lane carries it.
   function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] wdata);
      case (size)
         SZ_BYTE: lane_data = {4{wdata[7:0]}};
         SZ_HALF: lane_data = {2{wdata[15:0]}};
         default: lane_data = wdata;
      endcase
   endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load alignment: shifts the addressed lane(s) of a memory word down to bit 0
// and zero- or sign-extends them to 32 bits. Word loads pass straight through.
module dmem_load_align
   import byte_data_memory_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  offset,
   input  logic [1:0]  size,
   input  logic        zero_ext,
   output logic [31:0] result
);

   logic [31:0] shifted;

   // Shift the selected lane down, then extend according to size and signedness.
   always_comb begin
      shifted = word >> {offset, 3'b000};
      result  = '0;
      case (size)
         SZ_BYTE: result = zero_ext ? {24'd0, shifted[7:0]}
                                    : {{24{shifted[7]}}, shifted[7:0]};
         SZ_HALF: result = zero_ext ? {16'd0, shifted[15:0]}
                                    : {{16{shifted[15]}}, shifted[15:0]};
         SZ_WORD: result = word;
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/byte_data_memory.sv
// Byte-addressed data memory with a valid/ready request port, in-order
// responses after RD_LAT cycles, error reporting and a post-reset clear pass.
// Handshake: a request is taken on a rising edge where req_valid && req_ready;
// every taken request yields exactly one rsp_valid pulse, never back-pressured.
module byte_data_memory
   import byte_data_memory_pkg::*;
#(
   parameter int ADDR_W       = 10,
   parameter int RD_LAT       = 1,
   parameter int CLEAR_ON_RST = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        init_done
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [31:0]       mem [DEPTH];
   state_e            state_q, state_d;
   logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;

   logic [ADDR_W-1:0] idx;
   logic [1:0]        off;
   logic              req_err, accept, store_en, clear_en;
   logic [3:0]        wmask;
   logic [31:0]       wlanes;

   // First response stage: read word plus the attributes needed to align it.
   logic              s1_valid, s1_err, s1_we, s1_zext;
   logic [1:0]        s1_size, s1_off;
   logic [31:0]       s1_word, s1_aligned, s1_rdata;

   assign idx      = req_addr[ADDR_W+1:2];
   assign off      = req_addr[1:0];
   assign req_err  = (req_size == SZ_RSVD)
                   | ((req_size == SZ_HALF) & off[0])
                   | ((req_size == SZ_WORD) & (off != 2'b00))
                   | ((req_addr >> (ADDR_W + 2)) != 32'd0);

   // Ready and init_done drop with rst so nothing is accepted during reset.
   assign req_ready = (state_q == RUN) & ~rst;
   assign init_done = (state_q == RUN) & ~rst;
   assign accept    = req_valid & req_ready;
   assign store_en  = accept & req_we & ~req_err;
   assign clear_en  = (state_q == CLEAR) & ~rst;
   assign wmask     = lane_mask(req_size, off);
   assign wlanes    = lane_data(req_size, req_wdata);

   // Sequencer state and clear counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= (CLEAR_ON_RST != 0) ? CLEAR : RUN;
         clr_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
      end
   end

   // Clear walks every word once, then hands over to normal operation.
   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      case (state_q)
         CLEAR: begin
            clr_cnt_d = clr_cnt_q + ADDR_W'(1);
            if (clr_cnt_q == {ADDR_W{1'b1}}) state_d = RUN;
         end
         default: state_d = RUN;
      endcase
   end

   // Storage: clear writes, lane-masked stores, and the read at acceptance.
   always_ff @(posedge clk) begin
      if (clear_en) begin
         mem[clr_cnt_q] <= '0;
      end else if (store_en) begin
         for (int i = 0; i < 4; i++) begin
            if (wmask[i]) mem[idx][8*i +: 8] <= wlanes[8*i +: 8];
         end
      end
      if (accept) s1_word <= mem[idx];
   end

   // Request attributes travelling alongside the read word.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_err   <= 1'b0;
         s1_we    <= 1'b0;
         s1_zext  <= 1'b0;
         s1_size  <= 2'b00;
         s1_off   <= 2'b00;
      end else begin
         s1_valid <= accept;
         if (accept) begin
            s1_err  <= req_err;
            s1_we   <= req_we;
            s1_zext <= req_unsigned;
            s1_size <= req_size;
            s1_off  <= off;
         end
      end
   end

   dmem_load_align u_align (
      .word     (s1_word),
      .offset   (s1_off),
      .size     (s1_size),
      .zero_ext (s1_zext),
      .result   (s1_aligned)
   );

   // Stores and errored requests respond with zero data.
   assign s1_rdata = (s1_valid & ~s1_err & ~s1_we) ? s1_aligned : 32'd0;

   if (RD_LAT == 2) begin : g_lat2
      // Extra output register stage.
      always_ff @(posedge clk) begin
         if (rst) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
         end else begin
            rsp_valid <= s1_valid;
            rsp_rdata <= s1_rdata;
            rsp_err   <= s1_valid & s1_err;
         end
      end
   end else begin : g_lat1
      assign rsp_valid = s1_valid;
      assign rsp_rdata = s1_rdata;
      assign rsp_err   = s1_valid & s1_err;
   end

endmodule

// File: tb/tb_byte_data_memory.sv
// Bench for byte_data_memory: one instance per read latency, both driven by
// the same request stream, each with its own expected-response queue.
module tb_byte_data_memory;

  localparam int AW    = 4;
  localparam int DEPTH = 16;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;

  logic        ready1, ready2, valid1, valid2, err1, err2, done1, done2;
  logic [31:0] rdata1, rdata2;

  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  rsp_t        exp_q1[$];
  rsp_t        exp_q2[$];
  logic [31:0] model [DEPTH];

  byte_data_memory #(.ADDR_W(AW), .RD_LAT(1), .CLEAR_ON_RST(1)) u_lat1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready1),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(valid1),
    .rsp_rdata(rdata1), .rsp_err(err1), .init_done(done1)
  );

  byte_data_memory #(.ADDR_W(AW), .RD_LAT(2), .CLEAR_ON_RST(1)) u_lat2 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready2),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(valid2),
    .rsp_rdata(rdata2), .rsp_err(err2), .init_done(done2)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // reference model
  function automatic logic model_err(input logic [1:0] size, input logic [31:0] addr);
    return (size == 2'b11) || (size == 2'b01 && addr[0]) ||
           (size == 2'b10 && addr[1:0] != 2'b00) || ((addr >> (AW + 2)) != 32'd0);
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] off,
                                             input logic [1:0] size, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    case (size)
      2'b00: begin
        b = w[8*off +: 8];
        return uns ? {24'd0, b} : {{24{b[7]}}, b};
      end
      2'b01: begin
        h = off[1] ? w[31:16] : w[15:0];
        return uns ? {16'd0, h} : {{16{h[15]}}, h};
      end
      2'b10:   return w;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_store(input logic [3:0] idx, input logic [1:0] off,
                             input logic [1:0] size, input logic [31:0] wdata);
    for (int i = 0; i < 4; i++) begin
      if (size == 2'b00 && i == int'(off))
        model[idx][8*i +: 8] = wdata[7:0];
      else if (size == 2'b01 && (i / 2) == int'(off[1]))
        model[idx][8*i +: 8] = (i % 2 == 1) ? wdata[15:8] : wdata[7:0];
      else if (size == 2'b10)
        model[idx][8*i +: 8] = wdata[8*i +: 8];
    end
  endtask

  // driver: one request per call, accepted at the following rising edge
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    rsp_t e;
    logic er;
    @(negedge clk);
    req_valid = 1'b1;
    req_we = we;
    req_size = size;
    req_unsigned = uns;
    req_addr = addr;
    req_wdata = wdata;
    #1;
    check("ready_lat1", 32'(ready1), 32'd1);
    check("ready_lat2", 32'(ready2), 32'd1);
    er = model_err(size, addr);
    e.err = er;
    e.rdata = (we || er) ? 32'd0 : model_load(model[addr[5:2]], addr[1:0], size, uns);
    if (we && !er) model_store(addr[5:2], addr[1:0], size, wdata);
    e.cyc = cyc + 1;
    exp_q1.push_back(e);
    e.cyc = cyc + 2;
    exp_q2.push_back(e);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Assert rst across one edge; responses not yet visible are discarded.
  task automatic start_reset();
    rst = 1'b1;
    while (exp_q1.size() != 0 && exp_q1[$].cyc > cyc) void'(exp_q1.pop_back());
    while (exp_q2.size() != 0 && exp_q2[$].cyc > cyc) void'(exp_q2.pop_back());
    @(posedge clk);
    @(negedge clk);
    check("rst_ready1", 32'(ready1), 32'd0);
    check("rst_ready2", 32'(ready2), 32'd0);
    check("rst_valid1", 32'(valid1), 32'd0);
    check("rst_valid2", 32'(valid2), 32'd0);
    check("rst_rdata1", rdata1, 32'd0);
    check("rst_rdata2", rdata2, 32'd0);
    check("rst_err1", 32'(err1), 32'd0);
    check("rst_err2", 32'(err2), 32'd0);
    check("rst_done1", 32'(done1), 32'd0);
    check("rst_done2", 32'(done2), 32'd0);
    for (int i = 0; i < DEPTH; i++) model[i] = 32'd0;
    rst = 1'b0;
    #1;
  endtask

  // Count cycles with req_ready low after rst release (bounded).
  task automatic wait_clear();
    int n = 0;
    while (ready1 !== 1'b1 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("clear_len", 32'(n), 32'(DEPTH));
    check("clear_ready2", 32'(ready2), 32'd1);
    check("clear_done1", 32'(done1), 32'd1);
    check("clear_done2", 32'(done2), 32'd1);
  endtask

  // scoreboard: RD_LAT=1 instance
  always @(negedge clk) begin : mon1
    rsp_t e;
    if (valid1 === 1'b1) begin
      if (exp_q1.size() == 0) begin
        check("lat1_spurious", 32'(valid1), 32'd0);
      end else begin
        e = exp_q1.pop_front();
        check("lat1_rdata", rdata1, e.rdata);
        check("lat1_err", 32'(err1), 32'(e.err));
        check("lat1_cycle", 32'(cyc), 32'(e.cyc));
      end
    end else if (exp_q1.size() != 0 && exp_q1[0].cyc <= cyc) begin
      e = exp_q1.pop_front();
      check("lat1_missing", 32'(valid1), 32'd1);
    end
  end

  // scoreboard: RD_LAT=2 instance
  always @(negedge clk) begin : mon2
    rsp_t e;
    if (valid2 === 1'b1) begin
      if (exp_q2.size() == 0) begin
        check("lat2_spurious", 32'(valid2), 32'd0);
      end else begin
        e = exp_q2.pop_front();
        check("lat2_rdata", rdata2, e.rdata);
        check("lat2_err", 32'(err2), 32'(e.err));
        check("lat2_cycle", 32'(cyc), 32'(e.cyc));
      end
    end else if (exp_q2.size() != 0 && exp_q2[0].cyc <= cyc) begin
      e = exp_q2.pop_front();
      check("lat2_missing", 32'(valid2), 32'd1);
    end
  end

  initial begin
    int w;
    start_reset();
    wait_clear();

    // cleared contents
    for (int a = 0; a < 64; a += 4) issue(1'b0, 2'b10, 1'b0, 32'(a), 32'd0);

    // word store/load, byte merge, sub-word loads
    issue(1'b1, 2'b10, 1'b0, 32'h8, 32'hDEADBEEF);
    issue(1'b0, 2'b10, 1'b0, 32'h8, 32'd0);
    issue(1'b1, 2'b00, 1'b0, 32'h9, 32'h0000007F);
    issue(1'b0, 2'b10, 1'b0, 32'h8, 32'd0);
    issue(1'b0, 2'b00, 1'b0, 32'hB, 32'd0);
    issue(1'b0, 2'b00, 1'b1, 32'hB, 32'd0);
    issue(1'b0, 2'b01, 1'b0, 32'hA, 32'd0);
    issue(1'b0, 2'b01, 1'b1, 32'h8, 32'd0);

    // error cases
    issue(1'b1, 2'b10, 1'b0, 32'h4, 32'h11223344);
    issue(1'b1, 2'b10, 1'b0, 32'h6, 32'h12345678);
    issue(1'b0, 2'b10, 1'b0, 32'h4, 32'd0);
    issue(1'b0, 2'b11, 1'b0, 32'h0, 32'd0);
    issue(1'b0, 2'b10, 1'b0, 32'h40, 32'd0);
    issue(1'b1, 2'b01, 1'b0, 32'h5, 32'h0000ABCD);
    issue(1'b1, 2'b01, 1'b0, 32'h6, 32'h0000ABCD);
    issue(1'b0, 2'b10, 1'b0, 32'h4, 32'd0);

    // back-to-back loads
    issue(1'b0, 2'b10, 1'b0, 32'h0, 32'd0);
    issue(1'b0, 2'b10, 1'b0, 32'h4, 32'd0);
    issue(1'b0, 2'b10, 1'b0, 32'h8, 32'd0);

    // random traffic with occasional idle cycles
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            32'($urandom_range(0, 'h47)), $urandom);
    end

    // reset with a load in flight, then again partway through the clear
    issue(1'b0, 2'b10, 1'b0, 32'h8, 32'd0);
    start_reset();
    repeat (5) @(negedge clk);
    check("midclear_ready", 32'(ready1), 32'd0);
    start_reset();
    wait_clear();
    issue(1'b0, 2'b10, 1'b0, 32'h8, 32'd0);
    issue(1'b0, 2'b10, 1'b0, 32'h4, 32'd0);

    // drain
    w = 0;
    while ((exp_q1.size() != 0 || exp_q2.size() != 0) && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("drain", 32'(exp_q1.size() + exp_q2.size()), 32'd0);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
